// File: rtl/snitch_icache_l0_perf_cnt.sv
// Performance counter bank for the L0 instruction cache events of every
// fetch port. Live counters run from the event levels; a shadow bank holds
// a snapshot that is read through a valid/ready request/response port.
module snitch_icache_l0_perf_cnt #(
   parameter int NR_PORTS      = 4,
   parameter int COUNTER_WIDTH = 32,
   parameter int SATURATE      = 0,
   parameter int PORT_IW       = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         enable_i,
   input  logic                         clear_i,
   input  logic [NR_PORTS*5-1:0]        events_i,
   input  logic                         snapshot_i,
   input  logic                         rd_valid_i,
   output logic                         rd_ready_o,
   input  logic [PORT_IW-1:0]           rd_port_i,
   input  logic [2:0]                   rd_event_i,
   output logic                         rsp_valid_o,
   input  logic                         rsp_ready_i,
   output logic [COUNTER_WIDTH-1:0]     rsp_data_o,
   output logic                         rsp_error_o,
   output logic [NR_PORTS*5-1:0]        overflow_o
);

   localparam int NR_EVENTS = 5;
   localparam int NR_CNT    = NR_PORTS * NR_EVENTS;
   localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};

   logic [NR_CNT-1:0][COUNTER_WIDTH-1:0] cnt_q, cnt_d;
   logic [NR_CNT-1:0][COUNTER_WIDTH-1:0] shadow_q, shadow_d;
   logic [NR_CNT-1:0]                    ovf_q, ovf_d;

   logic                     rsp_valid_q, rsp_valid_d;
   logic                     rsp_err_q, rsp_err_d;
   logic [COUNTER_WIDTH-1:0] rsp_data_q, rsp_data_d;

   logic                     rd_accept;
   logic                     rd_err;
   logic [COUNTER_WIDTH-1:0] rd_sel;

   // Live counters: clear wins over increment; all-ones either wraps or holds and flags overflow
   always_comb begin
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      for (int i = 0; i < NR_CNT; i++) begin
         if (clear_i) begin
            cnt_d[i] = '0;
            ovf_d[i] = 1'b0;
         end else if (enable_i && events_i[i]) begin
            if (cnt_q[i] == CNT_MAX) begin
               ovf_d[i] = 1'b1;
               cnt_d[i] = (SATURATE != 0) ? CNT_MAX : '0;
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
         end
      end
   end

   // Shadow bank captures the live values as they stood before this cycle's update
   always_comb begin
      shadow_d = snapshot_i ? cnt_q : shadow_q;
   end

   // Decode the read index and select the shadow value; out-of-range reads return zero
   always_comb begin
      rd_err = (int'(rd_port_i) >= NR_PORTS) || (rd_event_i >= 3'd5);
      rd_sel = '0;
      for (int p = 0; p < NR_PORTS; p++) begin
         for (int e = 0; e < NR_EVENTS; e++) begin
            if ((int'(rd_port_i) == p) && (int'(rd_event_i) == e)) begin
               rd_sel = shadow_q[p*NR_EVENTS+e];
            end
         end
      end
   end

   assign rd_ready_o = !rsp_valid_q || rsp_ready_i;
   assign rd_accept  = rd_valid_i && rd_ready_o;

   // Single response slot: load on accept, release on drain, otherwise hold
   always_comb begin
      rsp_valid_d = rsp_valid_q;
      rsp_err_d   = rsp_err_q;
      rsp_data_d  = rsp_data_q;
      if (rd_accept) begin
         rsp_valid_d = 1'b1;
         rsp_err_d   = rd_err;
         rsp_data_d  = rd_err ? '0 : rd_sel;
      end else if (rsp_ready_i) begin
         rsp_valid_d = 1'b0;
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q       <= '0;
         shadow_q    <= '0;
         ovf_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         cnt_q       <= cnt_d;
         shadow_q    <= shadow_d;
         ovf_q       <= ovf_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   assign rsp_valid_o = rsp_valid_q;
   assign rsp_error_o = rsp_err_q;
   assign rsp_data_o  = rsp_data_q;
   assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_snitch_icache_l0_perf_cnt.sv
// Bench for the L0 performance counter bank: a wrapping and a saturating
// instance share one stimulus stream; a reference model predicts counters,
// flags and read responses, which are queued on accept and checked on output.
module tb_snitch_icache_l0_perf_cnt;

   localparam int NP = 3;
   localparam int CW = 4;
   localparam int NB = NP * 5;

   logic          clk = 1'b0;
   logic          rst_i, enable_i, clear_i, snapshot_i, rd_valid_i, rsp_ready_i;
   logic [NB-1:0] events_i;
   logic [1:0]    rd_port_i;
   logic [2:0]    rd_event_i;

   logic          rd_ready_w, rsp_valid_w, rsp_error_w;
   logic [CW-1:0] rsp_data_w;
   logic [NB-1:0] ovf_w;
   logic          rd_ready_s, rsp_valid_s, rsp_error_s;
   logic [CW-1:0] rsp_data_s;
   logic [NB-1:0] ovf_s;

   snitch_icache_l0_perf_cnt #(.NR_PORTS(NP), .COUNTER_WIDTH(CW), .SATURATE(0)) dut_w (
      .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .clear_i(clear_i),
      .events_i(events_i), .snapshot_i(snapshot_i), .rd_valid_i(rd_valid_i),
      .rd_ready_o(rd_ready_w), .rd_port_i(rd_port_i), .rd_event_i(rd_event_i),
      .rsp_valid_o(rsp_valid_w), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_w),
      .rsp_error_o(rsp_error_w), .overflow_o(ovf_w)
   );

   snitch_icache_l0_perf_cnt #(.NR_PORTS(NP), .COUNTER_WIDTH(CW), .SATURATE(1)) dut_s (
      .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .clear_i(clear_i),
      .events_i(events_i), .snapshot_i(snapshot_i), .rd_valid_i(rd_valid_i),
      .rd_ready_o(rd_ready_s), .rd_port_i(rd_port_i), .rd_event_i(rd_event_i),
      .rsp_valid_o(rsp_valid_s), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_s),
      .rsp_error_o(rsp_error_s), .overflow_o(ovf_s)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          err;
      logic [CW-1:0] dw;
      logic [CW-1:0] ds;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   bit   pend    = 1'b0;

   // reference model: live, shadow and overflow for wrap (w) and saturate (s)
   bit [CW-1:0] lw[NB];
   bit [CW-1:0] ls[NB];
   bit [CW-1:0] sw[NB];
   bit [CW-1:0] ss[NB];
   bit          ow[NB];
   bit          os[NB];

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
      end
   endtask

   task automatic model_edge();
      for (int i = 0; i < NB; i++) begin
         if (rst_i) begin
            lw[i] = '0; ls[i] = '0; sw[i] = '0; ss[i] = '0; ow[i] = 1'b0; os[i] = 1'b0;
         end else begin
            if (snapshot_i) begin
               sw[i] = lw[i];
               ss[i] = ls[i];
            end
            if (clear_i) begin
               lw[i] = '0; ls[i] = '0; ow[i] = 1'b0; os[i] = 1'b0;
            end else if (enable_i && events_i[i]) begin
               if (lw[i] == 4'hF) begin
                  lw[i] = 4'h0;
                  ow[i] = 1'b1;
               end else begin
                  lw[i] = lw[i] + 4'd1;
               end
               if (ls[i] == 4'hF) os[i] = 1'b1;
               else ls[i] = ls[i] + 4'd1;
            end
         end
      end
   endtask

   // One clock cycle: check outputs at the falling edge, then advance model and DUT
   task automatic step();
      bit   exp_ready, acc;
      exp_t e;
      int   idx;
      @(negedge clk);
      exp_ready = !pend || rsp_ready_i;
      if (!rst_i) begin
         chk("rd_ready_w", 64'(rd_ready_w), 64'(exp_ready));
         chk("rd_ready_s", 64'(rd_ready_s), 64'(exp_ready));
         chk("rsp_valid_w", 64'(rsp_valid_w), 64'(pend));
         chk("rsp_valid_s", 64'(rsp_valid_s), 64'(pend));
         if (pend) begin
            if (sb.size() == 0) begin
               chk("sb_nonempty", 64'(sb.size()), 64'(1));
            end else begin
               e = sb[0];
               chk("rsp_err_w", 64'(rsp_error_w), 64'(e.err));
               chk("rsp_err_s", 64'(rsp_error_s), 64'(e.err));
               chk("rsp_data_w", 64'(rsp_data_w), 64'(e.dw));
               chk("rsp_data_s", 64'(rsp_data_s), 64'(e.ds));
            end
         end
         for (int i = 0; i < NB; i++) begin
            chk($sformatf("ovf_w[%0d]", i), 64'(ovf_w[i]), 64'(ow[i]));
            chk($sformatf("ovf_s[%0d]", i), 64'(ovf_s[i]), 64'(os[i]));
         end
      end
      acc = rd_valid_i && exp_ready;
      if (rst_i) begin
         pend = 1'b0;
         sb.delete();
      end else begin
         if (pend && rsp_ready_i) begin
            if (sb.size() != 0) void'(sb.pop_front());
            pend = 1'b0;
         end
         if (acc) begin
            e.err = (int'(rd_port_i) >= NP) || (int'(rd_event_i) >= 5);
            idx   = int'(rd_port_i) * 5 + int'(rd_event_i);
            e.dw  = e.err ? 4'h0 : sw[idx];
            e.ds  = e.err ? 4'h0 : ss[idx];
            sb.push_back(e);
            pend = 1'b1;
         end
      end
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic read(input int p, input int ev);
      rd_valid_i = 1'b1;
      rd_port_i  = 2'(p);
      rd_event_i = 3'(ev);
      step();
      rd_valid_i = 1'b0;
   endtask

   initial begin
      rst_i = 1'b1; enable_i = 1'b0; clear_i = 1'b0; snapshot_i = 1'b0;
      rd_valid_i = 1'b0; rsp_ready_i = 1'b1; events_i = '0;
      rd_port_i = 2'd0; rd_event_i = 3'd0;
      repeat (2) step();
      rst_i = 1'b0;

      // reset state
      chk("rst_rsp_valid", 64'(rsp_valid_w), 64'(0));
      chk("rst_rsp_data", 64'(rsp_data_w), 64'(0));
      chk("rst_rsp_err", 64'(rsp_error_s), 64'(0));
      chk("rst_ovf", 64'(ovf_w | ovf_s), 64'(0));
      chk("rst_rd_ready", 64'(rd_ready_w), 64'(1));

      // port 1 hit for 7 cycles; snapshot with a simultaneous read returns the old shadow
      enable_i = 1'b1;
      events_i[8] = 1'b1;
      repeat (7) step();
      events_i = '0;
      snapshot_i = 1'b1;
      read(1, 3);
      snapshot_i = 1'b0;
      read(1, 3);
      read(0, 3);
      step();

      // port 0 miss for 17 cycles: wrap gives 1, saturate gives 15, flag set in both
      clear_i = 1'b1; step(); clear_i = 1'b0;
      events_i[4] = 1'b1;
      repeat (17) step();
      events_i = '0;
      snapshot_i = 1'b1; step(); snapshot_i = 1'b0;
      read(0, 4);
      step();
      chk("ovf_miss0_w", 64'(ovf_w[4]), 64'(1));
      chk("ovf_miss0_s", 64'(ovf_s[4]), 64'(1));

      // atomic read-and-clear on port 2 miss; also drops the port 0 flags
      events_i[14] = 1'b1;
      repeat (3) step();
      snapshot_i = 1'b1; clear_i = 1'b1;
      step();
      snapshot_i = 1'b0; clear_i = 1'b0;
      chk("rac_ovf_cleared", 64'(ovf_w | ovf_s), 64'(0));
      read(2, 4);
      step();
      events_i = '0;
      snapshot_i = 1'b1; step(); snapshot_i = 1'b0;
      read(2, 4);
      step();

      // backpressure: held request accepted once, then full throughput
      rsp_ready_i = 1'b0;
      rd_valid_i = 1'b1; rd_port_i = 2'd1; rd_event_i = 3'd3;
      repeat (3) step();
      rsp_ready_i = 1'b1;
      for (int i = 0; i < 6; i++) begin
         rd_port_i  = 2'(i % 3);
         rd_event_i = 3'(i % 5);
         step();
      end
      rd_valid_i = 1'b0;
      step();

      // out-of-range indices
      read(3, 0);
      read(0, 5);
      read(2, 7);
      step();

      // reset with a pending response of 9
      clear_i = 1'b1; step(); clear_i = 1'b0;
      events_i[5] = 1'b1;
      repeat (9) step();
      events_i = '0;
      snapshot_i = 1'b1; step(); snapshot_i = 1'b0;
      rsp_ready_i = 1'b0;
      read(1, 0);
      step();
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      chk("rst_pending_valid_w", 64'(rsp_valid_w), 64'(0));
      chk("rst_pending_valid_s", 64'(rsp_valid_s), 64'(0));
      rsp_ready_i = 1'b1;
      snapshot_i = 1'b1; step(); snapshot_i = 1'b0;
      read(1, 0);
      step();

      chk("sb_drained", 64'(sb.size()), 64'(0));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
